// File: rtl/sata_rx_aligner_if.sv
// Receive-side bundle between the GTX receiver, the dword aligner and the link layer.
// master = transceiver/link side, slave = aligner.
interface sata_rx_aligner_if;
    logic [31:0] rxdata_fis;
    logic [3:0]  rxcharisk;
    logic        rx_los;
    logic [31:0] phy2cs_data;
    logic        phy2cs_k;
    logic        phy2cs_valid;
    logic        link_up;
    logic [1:0]  byte_offset;
    logic [7:0]  align_err_cnt;

    modport master (
        output rxdata_fis,
        output rxcharisk,
        output rx_los,
        input  phy2cs_data,
        input  phy2cs_k,
        input  phy2cs_valid,
        input  link_up,
        input  byte_offset,
        input  align_err_cnt
    );

    modport slave (
        input  rxdata_fis,
        input  rxcharisk,
        input  rx_los,
        output phy2cs_data,
        output phy2cs_k,
        output phy2cs_valid,
        output link_up,
        output byte_offset,
        output align_err_cnt
    );
endinterface

// File: rtl/sata_rx_aligner.sv
// SATA receive dword aligner: finds the K28.5 lane, verifies ALIGN primitives, then
// delivers dword-aligned data until lock is lost.
module sata_rx_aligner #(
    parameter int unsigned C_LOCK_CNT   = 3,
    parameter int unsigned C_UNLOCK_CNT = 2
) (
    input logic              phyclk,
    input logic              phyreset_n,
    sata_rx_aligner_if.slave bus
);

    localparam logic [31:0] AlignPrim = 32'h7B4A4ABC;
    localparam logic [3:0]  LockCnt   = 4'(C_LOCK_CNT);
    localparam logic [3:0]  UnlockCnt = 4'(C_UNLOCK_CNT);

    typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

    state_e      state_q, state_d;
    logic [31:0] r0_q;
    logic [3:0]  r0k_q;
    logic [1:0]  offset_q, offset_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d;
    logic [3:0]  miss_cnt_q, miss_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [31:0] data_q;
    logic        k_q;
    logic        valid_q;

    logic [31:0] aligned_data;
    logic [3:0]  aligned_k;
    logic        align_hit;
    logic        det;
    logic [1:0]  det_lane;
    logic        err_inc;

    // Aligned word spans the previous dword (r0) and the current one.
    always_comb begin
        aligned_data = r0_q;
        aligned_k    = r0k_q;
        unique case (offset_q)
            2'd0: begin
                aligned_data = r0_q;
                aligned_k    = r0k_q;
            end
            2'd1: begin
                aligned_data = {bus.rxdata_fis[7:0], r0_q[31:8]};
                aligned_k    = {bus.rxcharisk[0], r0k_q[3:1]};
            end
            2'd2: begin
                aligned_data = {bus.rxdata_fis[15:0], r0_q[31:16]};
                aligned_k    = {bus.rxcharisk[1:0], r0k_q[3:2]};
            end
            2'd3: begin
                aligned_data = {bus.rxdata_fis[23:0], r0_q[31:24]};
                aligned_k    = {bus.rxcharisk[2:0], r0k_q[3]};
            end
        endcase
    end

    assign align_hit = (aligned_data == AlignPrim) && (aligned_k == 4'b0001);

    // K28.5 on the raw dword; only a single K flag qualifies.
    always_comb begin
        det      = 1'b0;
        det_lane = 2'd0;
        case (bus.rxcharisk)
            4'b0001: begin
                det_lane = 2'd0;
                det      = (bus.rxdata_fis[7:0] == 8'hBC);
            end
            4'b0010: begin
                det_lane = 2'd1;
                det      = (bus.rxdata_fis[15:8] == 8'hBC);
            end
            4'b0100: begin
                det_lane = 2'd2;
                det      = (bus.rxdata_fis[23:16] == 8'hBC);
            end
            4'b1000: begin
                det_lane = 2'd3;
                det      = (bus.rxdata_fis[31:24] == 8'hBC);
            end
            default: begin
                det      = 1'b0;
                det_lane = 2'd0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        lock_cnt_d = lock_cnt_q;
        miss_cnt_d = miss_cnt_q;
        err_inc    = 1'b0;
        if (bus.rx_los) begin
            state_d    = StHunt;
            lock_cnt_d = 4'd0;
            miss_cnt_d = 4'd0;
            err_inc    = (state_q == StLocked);
        end else begin
            case (state_q)
                StHunt: begin
                    if (det) begin
                        offset_d   = det_lane;
                        lock_cnt_d = 4'd0;
                        state_d    = StVerify;
                    end
                end
                StVerify: begin
                    // A K28.5 on another lane retargets even if an ALIGN also completed.
                    if (det && (det_lane != offset_q)) begin
                        offset_d   = det_lane;
                        lock_cnt_d = 4'd0;
                    end else if (align_hit) begin
                        if (lock_cnt_q + 4'd1 == LockCnt) begin
                            state_d    = StLocked;
                            lock_cnt_d = 4'd0;
                            miss_cnt_d = 4'd0;
                        end else begin
                            lock_cnt_d = lock_cnt_q + 4'd1;
                        end
                    end
                end
                StLocked: begin
                    if (det && (det_lane != offset_q)) begin
                        if (miss_cnt_q + 4'd1 == UnlockCnt) begin
                            state_d    = StHunt;
                            miss_cnt_d = 4'd0;
                            err_inc    = 1'b1;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 4'd1;
                        end
                    end else if (align_hit) begin
                        miss_cnt_d = 4'd0;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
        err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge phyclk or negedge phyreset_n) begin
        if (!phyreset_n) begin
            state_q    <= StHunt;
            r0_q       <= 32'd0;
            r0k_q      <= 4'd0;
            offset_q   <= 2'd0;
            lock_cnt_q <= 4'd0;
            miss_cnt_q <= 4'd0;
            err_cnt_q  <= 8'd0;
            data_q     <= 32'd0;
            k_q        <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            r0_q       <= bus.rxdata_fis;
            r0k_q      <= bus.rxcharisk;
            offset_q   <= offset_d;
            lock_cnt_q <= lock_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            err_cnt_q  <= err_cnt_d;
            data_q     <= aligned_data;
            k_q        <= aligned_k[0];
            // A dword captured while the link is dropping is not delivered.
            valid_q    <= (state_q == StLocked) && !align_hit && !bus.rx_los;
        end
    end

    assign bus.phy2cs_data   = data_q;
    assign bus.phy2cs_k      = k_q;
    assign bus.phy2cs_valid  = valid_q;
    assign bus.link_up       = (state_q == StLocked);
    assign bus.byte_offset   = offset_q;
    assign bus.align_err_cnt = err_cnt_q;

endmodule
